// File: rtl/tb_score_pkg.sv
// Shared types for the tb_match scoreboard: section FSM states, the per-section record and saturating counters.
// Record widths are fixed here, so the scoreboard's CNT_W/SEC_W defaults must match them.
package tb_score_pkg;

    localparam int REC_CNT_W = 32;
    localparam int REC_SEC_W = 8;

    typedef enum logic [1:0] {
        SEC_IDLE   = 2'd0,
        SEC_ACTIVE = 2'd1,
        SEC_CLOSE  = 2'd2
    } sec_state_e;

    typedef struct packed {
        logic [REC_SEC_W-1:0] sec_idx;
        logic [REC_CNT_W-1:0] samples;
        logic [REC_CNT_W-1:0] mismatches;
    } sec_rec_t;

    // Counters stick at all-ones rather than wrapping back to a misleading small value.
    function automatic logic [REC_CNT_W-1:0] sat_inc(input logic [REC_CNT_W-1:0] v);
        return (&v) ? v : v + REC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/tb_match_scoreboard_if.sv
// Section record drain port: the scoreboard is master, the reporting logic is slave.
// Head fields hold steady while rec_valid is high and rec_ready is low.
interface tb_match_scoreboard_if #(
    parameter int CNT_W = 32,
    parameter int SEC_W = 8
);
    logic             rec_valid;
    logic             rec_ready;
    logic [SEC_W-1:0] rec_sec_idx;
    logic [CNT_W-1:0] rec_samples;
    logic [CNT_W-1:0] rec_mismatches;

    modport master (
        output rec_valid,
        output rec_sec_idx,
        output rec_samples,
        output rec_mismatches,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_sec_idx,
        input  rec_samples,
        input  rec_mismatches,
        output rec_ready
    );
endinterface

// File: rtl/tb_rec_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO of section records with count-based full/empty.
// Latency: a push is visible at the head one cycle later; the head is read straight from storage.
// Backpressure: push_rdy drops when full unless a pop happens on the same edge.
module tb_rec_fifo
    import tb_score_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_vld,
    output logic     push_rdy,
    input  sec_rec_t push_dat,
    output logic     pop_vld,
    input  logic     pop_rdy,
    output sec_rec_t pop_dat
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    sec_rec_t            mem_q [DEPTH];
    sec_rec_t            mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign pop_vld  = (count_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign do_pop   = pop_vld && pop_rdy;
    assign push_rdy = (count_q != FULL_CNT) || do_pop;
    assign do_push  = push_vld && push_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tb_match_scoreboard.sv
// Purpose: global pass/fail statistics on tb_match plus one summary record per wavedrom_enable section.
// Latency: counters update one cycle after the sample; a record reaches the FIFO two edges after enable falls.
// Backpressure: records wait in the FIFO on rec_ready; a push into a full FIFO without a pop is dropped and counted.
module tb_match_scoreboard
    import tb_score_pkg::*;
#(
    parameter int CNT_W = REC_CNT_W,
    parameter int SEC_W = REC_SEC_W,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tb_match,
    input  logic                  wavedrom_enable,
    output logic [CNT_W-1:0]      stat_samples,
    output logic [CNT_W-1:0]      stat_mismatches,
    output logic                  first_mis_valid,
    output logic [CNT_W-1:0]      first_mis_cycle,
    output logic                  pass,
    output logic [CNT_W-1:0]      rec_dropped,
    tb_match_scoreboard_if.master rec_if
);

    sec_state_e       state_q, state_d;
    logic [CNT_W-1:0] samples_q, samples_d;
    logic [CNT_W-1:0] mismatches_q, mismatches_d;
    logic             first_mis_valid_q, first_mis_valid_d;
    logic [CNT_W-1:0] first_mis_cycle_q, first_mis_cycle_d;
    logic [SEC_W-1:0] sec_idx_q, sec_idx_d;
    logic [CNT_W-1:0] sec_samples_q, sec_samples_d;
    logic [CNT_W-1:0] sec_mis_q, sec_mis_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    logic     mis;
    logic     push;
    logic     push_rdy;
    logic     head_vld;
    sec_rec_t push_rec;
    sec_rec_t head_rec;

    // Anything that is not a clean 1, including X/Z, is a mismatch.
    assign mis      = (tb_match !== 1'b1);
    assign push_rec = '{sec_idx: sec_idx_q, samples: sec_samples_q, mismatches: sec_mis_q};

    always_comb begin
        samples_d         = sat_inc(samples_q);
        mismatches_d      = mis ? sat_inc(mismatches_q) : mismatches_q;
        first_mis_valid_d = first_mis_valid_q;
        first_mis_cycle_d = first_mis_cycle_q;
        if (mis && !first_mis_valid_q) begin
            first_mis_valid_d = 1'b1;
            first_mis_cycle_d = samples_q;
        end

        state_d       = state_q;
        sec_idx_d     = sec_idx_q;
        sec_samples_d = sec_samples_q;
        sec_mis_d     = sec_mis_q;
        push          = 1'b0;
        case (state_q)
            SEC_IDLE: begin
                if (wavedrom_enable) begin
                    state_d       = SEC_ACTIVE;
                    sec_samples_d = CNT_W'(1);
                    sec_mis_d     = CNT_W'(mis);
                end
            end
            SEC_ACTIVE: begin
                if (wavedrom_enable) begin
                    sec_samples_d = sat_inc(sec_samples_q);
                    sec_mis_d     = mis ? sat_inc(sec_mis_q) : sec_mis_q;
                end else begin
                    state_d = SEC_CLOSE;
                end
            end
            SEC_CLOSE: begin
                push      = 1'b1;
                sec_idx_d = sec_idx_q + SEC_W'(1);
                // Enable already back high: this cycle opens the next section.
                if (wavedrom_enable) begin
                    state_d       = SEC_ACTIVE;
                    sec_samples_d = CNT_W'(1);
                    sec_mis_d     = CNT_W'(mis);
                end else begin
                    state_d = SEC_IDLE;
                end
            end
            default: state_d = SEC_IDLE;
        endcase

        dropped_d = (push && !push_rdy) ? sat_inc(dropped_q) : dropped_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= SEC_IDLE;
            samples_q         <= '0;
            mismatches_q      <= '0;
            first_mis_valid_q <= 1'b0;
            first_mis_cycle_q <= '0;
            sec_idx_q         <= '0;
            sec_samples_q     <= '0;
            sec_mis_q         <= '0;
            dropped_q         <= '0;
        end else begin
            state_q           <= state_d;
            samples_q         <= samples_d;
            mismatches_q      <= mismatches_d;
            first_mis_valid_q <= first_mis_valid_d;
            first_mis_cycle_q <= first_mis_cycle_d;
            sec_idx_q         <= sec_idx_d;
            sec_samples_q     <= sec_samples_d;
            sec_mis_q         <= sec_mis_d;
            dropped_q         <= dropped_d;
        end
    end

    tb_rec_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_rdy (push_rdy),
        .push_dat (push_rec),
        .pop_vld  (head_vld),
        .pop_rdy  (rec_if.rec_ready),
        .pop_dat  (head_rec)
    );

    assign stat_samples          = samples_q;
    assign stat_mismatches       = mismatches_q;
    assign first_mis_valid       = first_mis_valid_q;
    assign first_mis_cycle       = first_mis_cycle_q;
    assign pass                  = (mismatches_q == '0);
    assign rec_dropped           = dropped_q;
    assign rec_if.rec_valid      = head_vld;
    assign rec_if.rec_sec_idx    = head_rec.sec_idx;
    assign rec_if.rec_samples    = head_rec.samples;
    assign rec_if.rec_mismatches = head_rec.mismatches;

endmodule

// File: doc/tb_match_scoreboard.md
# tb_match_scoreboard

Testbench-side checker that sits directly downstream of `stimulus_gen`. It consumes the per-cycle `tb_match` verdict and the `wavedrom_enable` section marker, and keeps global pass/fail statistics. For every enabled section it also produces a per-section summary record. Records are buffered in a small FIFO and drained over a valid/ready port by the bench's reporting logic.

## Interface

Parameters:
- `CNT_W`, 32, width of every sample/mismatch/cycle counter
- `SEC_W`, 8, width of section index
- `DEPTH`, 4, record FIFO depth (power of two, ≥2)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset; synchronous, active-high
- `tb_match` in 1: DUT-vs-reference match for this cycle
- `wavedrom_enable` in 1: high while a named test section is active
- `stat_samples` out CNT_W: total cycles sampled since reset
- `stat_mismatches` out CNT_W: total mismatching cycles
- `first_mis_valid` out 1: a mismatch has been seen
- `first_mis_cycle` out CNT_W: sample index of first mismatch
- `pass` out 1: `stat_mismatches == 0`
- `rec_valid` out 1: FIFO head record available
- `rec_ready` in 1: consumer accepts head record
- `rec_sec_idx` out SEC_W: section ordinal (0-based)
- `rec_samples` out CNT_W: cycles in that section
- `rec_mismatches` out CNT_W: mismatching cycles in that section
- `rec_dropped` out CNT_W: records lost to FIFO full

## Operation

- Sampling:
  - One sample on every `clk` posedge with `rst` low.
  - A mismatch is any `tb_match` value other than 1; X/Z count as mismatch.
- Global counters: `stat_samples` +1 per sample; `stat_mismatches` +1 per mismatch. All counters saturate at all-ones and never wrap.
- First mismatch:
  - On the first mismatch, latch `first_mis_cycle` = `stat_samples` value before increment, and set `first_mis_valid`.
  - Both are sticky until reset.
- Section FSM, states IDLE, ACTIVE, CLOSE:
  - IDLE → ACTIVE when `wavedrom_enable`=1. That cycle is counted as the section's first sample, and section counters load 1 / mismatch?1:0.
  - ACTIVE stays while enable=1 and accumulates.
  - ACTIVE → CLOSE when enable=0. That cycle is not counted in the section.
  - CLOSE pushes record {sec_idx, sec_samples, sec_mismatches}, increments `sec_idx` (wraps modulo 2^SEC_W), then:
    - → ACTIVE if enable=1 in the CLOSE cycle, with counters restarted with that cycle's sample;
    - otherwise → IDLE.
- FIFO:
  - Push in CLOSE; pop on `rec_valid && rec_ready`.
  - Push when full with a simultaneous pop: accepted.
  - Push when full without a pop: record dropped, `rec_dropped` +1 (saturating). `sec_idx` still advances, so gaps in the index are visible.
- Reset: clears all counters, flags, FIFO and pointers, `sec_idx`; FSM → IDLE. Reset mid-section discards the partial section and pushes no record.
- Reset values: all count outputs 0, `first_mis_valid`=0, `pass`=1, `rec_valid`=0, record fields 0.

## Timing

- Global counters and first-mismatch fields are registered. A sample at posedge N is reflected after posedge N.
- `pass` is combinational from `stat_mismatches`.
- Section close latency:
  - enable sampled low at posedge N: FSM in CLOSE during cycle N→N+1;
  - push at posedge N+1;
  - `rec_valid` high after posedge N+1 if the FIFO was empty.
- Record outputs come from FIFO head registers. They are stable while `rec_valid && !rec_ready`.
- Pop and push may occur on the same edge at any occupancy.

## Structure

- Package `tb_score_pkg`: FSM state enum `sec_state_e`, record struct `sec_rec_t` {sec_idx, samples, mismatches}, and a saturating-increment function.
- Sub-module `tb_rec_fifo`: synchronous FIFO of `sec_rec_t`, DEPTH entries, with count-based full/empty. The top module holds the FSM and counters.

## Test plan

- Reset then 10 cycles all `tb_match`=1, enable=0:
  - `stat_samples`=10, `pass`=1, `rec_valid`=0.
- Section with enable high 5 cycles, `tb_match`=0 on its 3rd cycle:
  - one record {idx 0, samples 5, mismatches 1};
  - `first_mis_cycle` = global index of that cycle; `pass`=0.
- Back-to-back sections: enable 1 for 3 cycles, 0 for one cycle, 1 for 4 cycles, 0:
  - records idx 0/samples 3 and idx 1/samples 4 (the CLOSE cycle with enable=1 restarts section 1).
- 6 one-cycle sections with `rec_ready`=0 and DEPTH=4:
  - 4 records held, `rec_dropped`=2;
  - draining yields idx 0–3 in order.
- Assert `rst` on the 3rd cycle of an active section:
  - no record pushed, all counters 0, next section gets idx 0.
- FIFO full, push coincides with `rec_ready`=1:
  - no drop, occupancy unchanged, head advances.
